// File: rtl/dv_uart_pkg.sv
// Shared definitions for the byte-stream UART transmitter: FSM encoding and frame shape.
package dv_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/dv_byte_fifo.sv
// Small synchronous byte FIFO with registered occupancy; pushes at full and pops at empty are ignored.
module dv_byte_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic               sclk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [7:0]         push_data,
    input  logic               pop,
    output logic [7:0]         pop_data,
    output logic [FIFO_AW:0]   level,
    output logic               full,
    output logic               empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (level == (FIFO_AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and level define which entries are valid.
    always_ff @(posedge sclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dv_uart_tx.sv
// Buffers strobed bytes and serialises them as 8N1 frames at CLKS_PER_BIT sclk cycles per bit.
module dv_uart_tx
    import dv_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,   // legal 2..65535
    parameter int FIFO_AW      = 2
) (
    input  logic               sclk,
    input  logic               rst_n,
    input  logic               i_dv,
    input  logic [7:0]         i_data,
    input  logic               i_ovf_clr,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_ovf,
    output logic [FIFO_AW:0]   o_level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

    state_t             state, state_nxt;
    logic [BAUD_W-1:0]  baud, baud_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [7:0]         shift, shift_nxt;
    logic               tx_nxt;
    logic               pop;
    logic               bit_done;
    logic [7:0]         head;
    logic               full;
    logic               empty;
    logic               push_ok;
    logic               drop;
    logic [FIFO_AW:0]   level_nxt;

    dv_byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .push      (i_dv),
        .push_data (i_data),
        .pop       (pop),
        .pop_data  (head),
        .level     (o_level),
        .full      (full),
        .empty     (empty)
    );

    assign push_ok  = i_dv && !full;
    assign drop     = i_dv && full;
    assign bit_done = (baud == BAUD_LAST);

    always_comb begin
        case ({push_ok, pop})
            2'b10:   level_nxt = o_level + 1'b1;
            2'b01:   level_nxt = o_level - 1'b1;
            default: level_nxt = o_level;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        idx_nxt   = idx;
        shift_nxt = shift;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        if (state != ST_IDLE) baud_nxt = bit_done ? '0 : baud + 1'b1;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    baud_nxt  = '0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                tx_nxt = 1'b0;
                if (bit_done) begin
                    state_nxt = ST_DATA;
                    idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                tx_nxt = shift[0];
                if (bit_done) begin
                    shift_nxt = shift >> 1;
                    idx_nxt   = idx + 1'b1;
                    if (idx == IDX_LAST) state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // o_tx is driven from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            baud   <= '0;
            idx    <= '0;
            shift  <= '0;
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
            o_ovf  <= 1'b0;
        end else begin
            state  <= state_nxt;
            baud   <= baud_nxt;
            idx    <= idx_nxt;
            shift  <= shift_nxt;
            o_tx   <= tx_nxt;
            o_busy <= (state_nxt != ST_IDLE) || (level_nxt != '0);
            if (drop)           o_ovf <= 1'b1;
            else if (i_ovf_clr) o_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dv_uart_tx.sv
// Drives two transmitter configurations with one stimulus stream and checks each cycle against a frame-position model.
module tb_dv_uart_tx;
    import dv_uart_pkg::*;

    localparam int NU    = 2;
    localparam int CPB_A = 4;
    localparam int AW_A  = 2;
    localparam int CPB_B = 2;
    localparam int AW_B  = 3;

    logic            sclk    = 1'b0;
    logic            rst_n   = 1'b0;
    logic            dv      = 1'b0;
    logic [7:0]      data    = 8'h00;
    logic            ovf_clr = 1'b0;
    logic            tx_a, busy_a, ovf_a;
    logic [AW_A:0]   level_a;
    logic            tx_b, busy_b, ovf_b;
    logic [AW_B:0]   level_b;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO as a queue, transmitter as a position within the current frame.
    int         cpb [NU] = '{CPB_A, CPB_B};
    int         dep [NU] = '{2 ** AW_A, 2 ** AW_B};
    logic [7:0] mq  [NU][$];
    int         m_t [NU];
    logic [7:0] m_cur [NU];
    logic       m_ovf [NU];
    logic       m_tx  [NU];
    int         maxlev_a;
    int         maxlev_b;
    logic       found;

    always #5 sclk = ~sclk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    dv_uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_AW(AW_A)) u_a (
        .sclk(sclk), .rst_n(rst_n), .i_dv(dv), .i_data(data), .i_ovf_clr(ovf_clr),
        .o_tx(tx_a), .o_busy(busy_a), .o_ovf(ovf_a), .o_level(level_a)
    );

    dv_uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_AW(AW_B)) u_b (
        .sclk(sclk), .rst_n(rst_n), .i_dv(dv), .i_data(data), .i_ovf_clr(ovf_clr),
        .o_tx(tx_b), .o_busy(busy_b), .o_ovf(ovf_b), .o_level(level_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            mq[u].delete();
            m_t[u]   = -1;
            m_cur[u] = 8'h00;
            m_ovf[u] = 1'b0;
            m_tx[u]  = 1'b1;
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c);
        for (int u = 0; u < NU; u++) begin
            logic full;
            int   bitn;
            full = (mq[u].size() == dep[u]);
            if (m_t[u] < 0) begin
                m_tx[u] = 1'b1;
            end else begin
                bitn = m_t[u] / cpb[u];
                if (bitn == 0)              m_tx[u] = 1'b0;
                else if (bitn <= DATA_BITS) m_tx[u] = m_cur[u][bitn-1];
                else                        m_tx[u] = 1'b1;
            end
            if (m_t[u] >= 0) begin
                m_t[u]++;
                if (m_t[u] == FRAME_BITS * cpb[u]) m_t[u] = -1;
            end else if (mq[u].size() != 0) begin
                m_cur[u] = mq[u].pop_front();
                m_t[u]   = 0;
            end
            if (v && !full) mq[u].push_back(d);
            if (v && full)  m_ovf[u] = 1'b1;
            else if (c)     m_ovf[u] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("tx_a",    tx_a,    m_tx[0]);
        check("busy_a",  busy_a,  (m_t[0] >= 0) || (mq[0].size() != 0));
        check("ovf_a",   ovf_a,   m_ovf[0]);
        check("level_a", level_a, mq[0].size());
        check("tx_b",    tx_b,    m_tx[1]);
        check("busy_b",  busy_b,  (m_t[1] >= 0) || (mq[1].size() != 0));
        check("ovf_b",   ovf_b,   m_ovf[1]);
        check("level_b", level_b, mq[1].size());
        if (int'(level_a) > maxlev_a) maxlev_a = int'(level_a);
        if (int'(level_b) > maxlev_b) maxlev_b = int'(level_b);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        dv      = v;
        data    = v ? d : 8'hxx;
        ovf_clr = c;
        @(posedge sclk);
        model_step(v, d, c);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_a",    tx_a,    1'b1);
        check("rst_level_a", level_a, 0);
        check("rst_tx_b",    tx_b,    1'b1);
        check("rst_level_b", level_b, 0);
        check("rst_ovf_a",   ovf_a,   1'b0);
        check("rst_busy_b",  busy_b,  1'b0);
        model_reset();
        dv      = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        maxlev_a = 0;
        maxlev_b = 0;
        repeat (3) @(negedge sclk);
        check("init_tx_a",    tx_a,    1'b1);
        check("init_busy_a",  busy_a,  1'b0);
        check("init_ovf_a",   ovf_a,   1'b0);
        check("init_level_a", level_a, 0);
        check("init_tx_b",    tx_b,    1'b1);
        check("init_level_b", level_b, 0);
        rst_n = 1'b1;

        // Idle line for 100 cycles.
        idle(100);

        // Single byte 0x07.
        idle(8);
        step(1'b1, 8'h07, 1'b0);
        check("one_level_a", level_a, 1);
        check("one_level_b", level_b, 1);
        idle(60);

        // Two consecutive bytes: the pop overlaps the second push.
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        check("pair_level_a", level_a, 1);
        check("pair_level_b", level_b, 1);
        idle(100);

        // Upstream pattern: 0x07 at cnt 0, 0x05 at cnt 2, period 8.
        maxlev_a = 0;
        for (int p = 0; p < 30; p++) begin
            for (int cnt = 0; cnt < 8; cnt++) begin
                step((cnt == 0) || (cnt == 2), (cnt == 0) ? 8'h07 : 8'h05, 1'b0);
            end
        end
        check("pat_maxlev_a", maxlev_a, 4);
        check("pat_ovf_a",    ovf_a,    1'b1);
        check("pat_ovf_b",    ovf_b,    1'b1);

        // Overflow clear, then clear colliding with a dropped push; start just after a pop of A.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            idle(1);
            if (m_t[0] == 0) found = 1'b1;
        end
        check("pop_wait", found, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        check("fill_level_a", level_a, 4);
        check("fill_ovf_a",   ovf_a,   1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("clr_ovf_a",    ovf_a,   1'b0);
        step(1'b1, 8'($urandom), 1'b1);
        check("setwins_ovf_a", ovf_a,  1'b1);
        idle(200);

        // Burst of 8 bytes into the deeper, faster instance.
        do_reset();
        maxlev_b = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0);
        idle(200);
        check("burst_maxlev_b", maxlev_b, 7);
        check("burst_ovf_b",    ovf_b,    1'b0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
        end
        idle(250);

        // Reset in the middle of the data bits of a 0x00 frame with one byte still queued.
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        idle(9);
        check("pre_rst_tx_a",    tx_a,    1'b0);
        check("pre_rst_level_a", level_a, 1);
        do_reset();
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
